// File: rtl/div241_pkg.sv
// rtl/div241_pkg.sv - shared widths, divisor constant and S2 payload type for the divide-by-241 scheduler
package div241_pkg;

  localparam int DIV_X_W  = 36;
  localparam int DIV_Q_W  = 29;
  localparam int DIV_R_W  = 8;
  localparam int DIVISOR  = 241;

  // Widest requester ID the scheduler supports (NUM_REQ up to 8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [DIV_Q_W-1:0]  q;
    logic [DIV_R_W-1:0]  r;
    logic [ID_MAX_W-1:0] id;
  } s2_payload_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_36_241.sv
// rtl/div_36_241.sv - combinational 36-bit divide by constant 241
module div_36_241 (
  input  logic [35:0] x,
  output logic [28:0] q,
  output logic [7:0]  r
);

  // floor((2^36-1)/241) fits in 29 bits and the remainder is below 241, so the casts drop only zeros.
  assign q = 29'(x / 36'd241);
  assign r = 8'(x % 36'd241);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting one past the last winner
module rr_arbiter
  import div241_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] cand;

  // The last-served requester is visited last, which gives strict rotation under full load.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (enable && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/div241_rr_sched.sv
// rtl/div241_rr_sched.sv - round-robin sharing of one divide-by-241 datapath with a two-stage backpressured pipeline
module div241_rr_sched
  import div241_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DIV_X_W-1:0] req_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIV_Q_W-1:0]         out_q,
  output logic [DIV_R_W-1:0]         out_r,
  output logic [ID_W-1:0]            out_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           done_cnt
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic               s1_valid;
  logic [DIV_X_W-1:0] s1_x;
  logic [ID_W-1:0]    s1_id;
  logic [DIV_X_W-1:0] sel_x;

  logic [DIV_Q_W-1:0] div_q;
  logic [DIV_R_W-1:0] div_r;
  s2_payload_t        s2;

  logic s2_adv;
  logic s1_free;
  logic out_fire;

  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  assign s1_free  = ~s1_valid | s2_adv;
  assign out_fire = out_valid & out_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (s1_free),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A grant is only ever raised on an asserted request, so grant_any marks a transfer.
  assign req_ready = grant;

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_x = sel_x | req_x[DIV_X_W*i +: DIV_X_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= ID_W'(NUM_REQ - 1);
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_id    <= '0;
    end else begin
      if (grant_any) begin
        ptr      <= grant_idx;
        s1_valid <= 1'b1;
        s1_x     <= sel_x;
        s1_id    <= grant_idx;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  div_36_241 u_div (
    .x (s1_x),
    .q (div_q),
    .r (div_r)
  );

  // A reload in the same cycle as a consume keeps out_valid high with the new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s2        <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        s2.q      <= div_q;
        s2.r      <= div_r;
        s2.id     <= ID_MAX_W'(s1_id);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_fire) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign out_q  = s2.q;
  assign out_r  = s2.r;
  assign out_id = ID_W'(s2.id);
  assign busy   = s1_valid | out_valid;

endmodule

// File: tb/tb_div241_rr_sched.sv
// tb/tb_div241_rr_sched.sv - randomized and directed bench for div241_rr_sched against a transaction-level model
module tb_div241_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*36-1:0]   req_x;
  logic                    out_valid;
  logic                    out_ready;
  logic [28:0]             out_q;
  logic [7:0]              out_r;
  logic [ID_W-1:0]         out_id;
  logic                    busy;
  logic [CNT_W-1:0]        done_cnt;

  always #5 clk = ~clk;

  div241_rr_sched #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_id    (out_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  typedef struct {
    logic [35:0] x;
    int          id;
    longint      acc_edge;
  } op_t;

  int n_vec = 0;
  int n_bad = 0;

  // Model: ops in flight in acceptance order, last grant, completed count.
  op_t         inflight[$];
  int          ptr_m;
  longint      edge_no;
  int          done_m;
  int          n_acc;
  logic [35:0] x_reg[NUM_REQ];
  int          mode;
  int          valid_pct;
  int          ready_pct;

  logic               s_out_valid;
  logic [28:0]        s_q;
  logic [7:0]         s_r;
  logic [ID_W-1:0]    s_id;
  logic [NUM_REQ-1:0] s_ready;
  int                 last_g;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [35:0] rand_x();
    case ($urandom_range(9))
      0:       return 36'd0;
      1:       return 36'd240;
      2:       return 36'd241;
      3:       return 36'hF_FFFF_FFFF;
      default: return 36'({$urandom, $urandom});
    endcase
  endfunction

  task automatic sync_x();
    for (int i = 0; i < NUM_REQ; i++) req_x[36*i +: 36] = x_reg[i];
  endtask

  task automatic model_reset();
    inflight.delete();
    ptr_m  = NUM_REQ - 1;
    done_m = 0;
    n_acc  = 0;
  endtask

  task automatic drive_next(input int g);
    if (mode == 0) begin
      if (g >= 0) req_valid[g] = 1'b0;
    end else if (mode == 2) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == g || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(99) < valid_pct);
          x_reg[i]     = rand_x();
        end
      end
      out_ready = ($urandom_range(99) < ready_pct);
    end
    sync_x();
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge, drive after it.
  task automatic step();
    int                 g;
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_ov;
    logic               fire;
    @(negedge clk);
    g = -1;
    if (inflight.size() < 2 || out_ready) g = pick(req_valid, ptr_m);
    exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
    exp_ov    = (inflight.size() > 0) && (edge_no > inflight[0].acc_edge);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("busy", 64'(busy), 64'(inflight.size() != 0));
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check("out_q", 64'(out_q), 64'(inflight[0].x / 36'd241));
      check("out_r", 64'(out_r), 64'(inflight[0].x % 36'd241));
      check("out_id", 64'(out_id), 64'(inflight[0].id));
    end
    check("done_cnt", 64'(done_cnt), 64'(done_m % 65536));
    s_out_valid = out_valid;
    s_q         = out_q;
    s_r         = out_r;
    s_id        = out_id;
    s_ready     = req_ready;
    last_g      = g;
    fire        = exp_ov && out_ready;
    @(posedge clk);
    edge_no++;
    if (fire) begin
      void'(inflight.pop_front());
      done_m++;
    end
    if (g >= 0) begin
      inflight.push_back('{x: x_reg[g], id: g, acc_edge: edge_no});
      ptr_m = g;
      n_acc++;
    end
    #1;
    drive_next(g);
  endtask

  task automatic run_single(input int id, input logic [35:0] x, input int eq, input int er);
    int acc;
    int d0;
    bit seen;
    acc  = -1;
    d0   = done_m;
    seen = 1'b0;
    mode = 0;
    out_ready = 1'b1;
    x_reg[id] = x;
    req_valid[id] = 1'b1;
    sync_x();
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (last_g == id && acc < 0) acc = c;
      if (s_out_valid) begin
        seen = 1'b1;
        check("single_latency", 64'(c - acc), 64'd2);
        check("single_q", 64'(s_q), 64'(eq));
        check("single_r", 64'(s_r), 64'(er));
        check("single_id", 64'(s_id), 64'(id));
      end
    end
    if (!seen) check("single_timeout", 64'd0, 64'd1);
    check("single_done", 64'(done_cnt), 64'((d0 + 1) % 65536));
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    mode      = 0;
    for (int c = 0; c < 10 && inflight.size() > 0; c++) step();
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic set_pattern();
    mode = 1;
    for (int i = 0; i < NUM_REQ; i++) x_reg[i] = 36'(i * 242);
    req_valid = '1;
    sync_x();
  endtask

  initial begin
    int start_acc;
    int cyc;
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    mode      = 0;
    valid_pct = 70;
    ready_pct = 75;
    edge_no   = 0;
    last_g    = -1;
    for (int i = 0; i < NUM_REQ; i++) x_reg[i] = '0;
    sync_x();
    model_reset();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_out_r", 64'(out_r), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_single(2, 36'd241007, 1000, 7);
    run_single(0, 36'd0, 0, 0);
    run_single(1, 36'd240, 0, 240);
    run_single(3, 36'd241, 1, 0);
    run_single(1, 36'hF_FFFF_FFFF, 285143056, 239);

    // Fill both stages, then reset mid-operation.
    set_pattern();
    out_ready = 1'b0;
    repeat (3) step();
    check("prefull_ready", 64'(s_ready), 64'd0);
    check("prefull_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done_cnt", 64'(done_cnt), 64'd0);
    model_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Continuous load: grants rotate from requester 0, one result per cycle.
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) check("first_grant", 64'(s_ready), 64'd1);
      if (c >= 2) begin
        check("tput_valid", 64'(s_out_valid), 64'd1);
        check("rot_id", 64'(s_id), 64'((c - 2) % NUM_REQ));
        check("pat_q", 64'(s_q), 64'(s_id));
        check("pat_r", 64'(s_r), 64'(s_id));
      end
    end

    // Output stall for five cycles.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      logic [28:0]     h_q;
      logic [7:0]      h_r;
      logic [ID_W-1:0] h_id;
      step();
      if (c == 0) begin
        h_q  = s_q;
        h_r  = s_r;
        h_id = s_id;
      end else begin
        check("stall_q", 64'(s_q), 64'(h_q));
        check("stall_r", 64'(s_r), 64'(h_r));
        check("stall_id", 64'(s_id), 64'(h_id));
        check("stall_ready", 64'(s_ready), 64'd0);
      end
      check("stall_valid", 64'(s_out_valid), 64'd1);
    end
    out_ready = 1'b1;
    repeat (8) step();
    drain();
    check("accept_vs_done", 64'(done_cnt), 64'(n_acc % 65536));

    // Random operands with random backpressure.
    mode      = 2;
    start_acc = n_acc;
    drive_next(-1);
    cyc = 0;
    while (n_acc - start_acc < 10000 && cyc < 40000) begin
      step();
      cyc++;
    end
    if (n_acc - start_acc < 10000) check("rand_budget", 64'(n_acc - start_acc), 64'd10000);
    drain();

    // Full-rate run long enough to wrap done_cnt.
    set_pattern();
    out_ready = 1'b1;
    cyc = 0;
    while (done_m < 65540 && cyc < 70000) begin
      step();
      cyc++;
    end
    if (done_m < 65540) check("wrap_budget", 64'(done_m), 64'd65540);
    drain();
    check("wrap_done_cnt", 64'(done_cnt), 64'(n_acc % 65536));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/div241_rr_sched.md
Name: div241_rr_sched

Overview:
- Shares one 36-bit divide-by-241 datapath (div_36_241: X[36] -> Q[29], R[8], purely combinational) among NUM_REQ requesters.
- Round-robin arbiter picks one requester per cycle.
- The operand is registered, divided, and the result is registered with the requester ID.
- Results leave through a single valid/ready output port with full backpressure; sits between DSP-side producers and result consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal clog2(NUM_REQ), minimum 1.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  NUM_REQ*36  packed operands; requester i occupies bits [36*i+35 : 36*i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_q  out  29  quotient floor(X/241).
- out_r  out  8  remainder X mod 241, always 0..240.
- out_id  out  ID_W  index of the originating requester.
- busy  out  1  high while either pipeline stage holds data.
- done_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system) clears:
  - s1_valid and out_valid to 0;
  - out_q, out_r, out_id, done_cnt to 0;
  - the round-robin pointer to NUM_REQ-1, so requester 0 has highest priority first.
- Two pipeline stages:
  - S1 holds the operand and ID; the divider is fed from S1.
  - S2 holds Q, R and ID and drives the out_* ports.
- Advance rules:
  - s2_adv = s1_valid & (!out_valid | out_ready).
  - s1_free = !s1_valid | s2_adv.
- Arbiter:
  - When s1_free is high, grant the first asserted req_valid searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[g] = 1 only for the granted g, and only when s1_free. It is combinational from req_valid, ptr and the pipeline state.
  - A transfer occurs when req_valid[g] & req_ready[g]. On transfer: ptr <= g, S1 loads req_x[g] and g, s1_valid <= 1.
  - With no valid requester, or s1_free low, all req_ready are 0 and ptr holds.
- S1 -> S2: on s2_adv, S2 loads the divider outputs and the S1 ID, and out_valid <= 1.
- Output handshake: when out_valid & out_ready and no s2_adv in the same cycle, out_valid <= 0.
- Latency: a request accepted in cycle n gives out_valid in cycle n+2 when the output is unstalled.
- Throughput: one result per cycle under continuous out_ready.
- Stall:
  - out_ready low holds out_* stable and out_valid high.
  - S1 holds its contents.
  - Once S1 is full, all req_ready drop.
  - No data is lost or duplicated.
- Simultaneous output consume and S2 reload in one cycle keeps out_valid at 1 with new data.
- done_cnt increments on each out_valid & out_ready and wraps modulo 2^CNT_W.
- busy = s1_valid | out_valid.
- Arithmetic:
  - out_q and out_r are exactly the div_36_241 outputs, registered.
  - Q*241 + R == X for all X in 0..2^36-1; Q max = 285143056.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,NUM_REQ-1,0,...
- A requester must hold req_valid and req_x stable until accepted; the block does not check this.
- Reset mid-operation discards both stages immediately; no partial results are emitted after reset release.

Decomposition:
- Shared package div241_pkg holds:
  - DIV_X_W=36, DIV_Q_W=29, DIV_R_W=8, DIVISOR=241;
  - a packed struct for the S2 payload {q, r, id}.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ; inputs req, ptr, enable; outputs one-hot grant and encoded index).
- The divider is instantiated unchanged as div_36_241.

Test Plan:
- Single request, X=241007 on requester 2, out_ready=1 -> out_valid two cycles after accept; out_q=1000, out_r=7, out_id=2; done_cnt=1.
- Boundary operands:
  - X=0 -> Q=0, R=0.
  - X=240 -> Q=0, R=240.
  - X=241 -> Q=1, R=0.
  - X=68719476735 -> Q=285143056, R=239.
- All four requesters continuously valid with X=i*241+i, out_ready=1 -> out_id sequence 0,1,2,3,0,...; each result has Q=i, R=i; one result per cycle.
- out_ready held low 5 cycles with all requesters valid -> out_* stable; req_ready all 0 after S1 fills; on release, results emerge in grant order with none lost; done_cnt matches accepted count.
- rst_n asserted while both stages are full -> out_valid=0, busy=0 and done_cnt=0 immediately; after release, first grant goes to requester 0.
- Random X (10k operands, random out_ready) -> every output satisfies Q*241+R==X with R<241, checked against a scoreboard in per-requester order; done_cnt wraps correctly past 65535.
